// File: rtl/nibble_packer.sv
// nibble_packer: packs NIB_W-bit nibbles LSB-first into NIBS-nibble words behind a one-deep output slot.
// Optional feature: define NIBBLE_PACKER_PARITY_EN to add out_par, the even parity of out_data.
module nibble_packer #(
    parameter  int NIB_W  = 4,
    parameter  int NIBS   = 4,
    localparam int WORD_W = NIB_W * NIBS,
    localparam int CNT_W  = $clog2(NIBS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cnt
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBS - 1);

    logic [WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_flush_pend;
    logic [WORD_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_out_valid;

    logic              w_slot_free;
    logic              w_in_beat;
    logic              w_complete;
    logic              w_flush_new;
    logic              w_flush_want;
    logic              w_flush_emit;
    logic              w_load;
    logic [WORD_W-1:0] w_acc_merge;
    logic [CNT_W-1:0]  w_cnt_merge;

    assign w_slot_free  = !r_out_valid || out_ready;
    assign in_ready     = rst_n && !r_flush_pend && ((r_cnt < LAST_IDX) || w_slot_free);
    assign w_in_beat    = in_valid && in_ready;
    assign w_complete   = w_in_beat && (r_cnt == LAST_IDX);
    // A flush that coincides with the completing beat is absorbed into the full word.
    assign w_flush_new  = flush && !r_flush_pend && ((r_cnt != '0) || w_in_beat) && !w_complete;
    assign w_flush_want = r_flush_pend || w_flush_new;
    assign w_flush_emit = w_flush_want && w_slot_free;
    assign w_load       = w_complete || w_flush_emit;
    assign w_cnt_merge  = r_cnt + {{(CNT_W-1){1'b0}}, w_in_beat};

    always_comb begin
        // NOTE: default assigned before the loop so no path leaves w_acc_merge unassigned (no latch).
        w_acc_merge = r_acc;
        for (int k = 0; k < NIBS; k++) begin
            if (w_in_beat && (r_cnt == CNT_W'(k))) begin
                w_acc_merge[k*NIB_W +: NIB_W] = in_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: accumulator is a plain register, so it is cleared here; padding relies on it being zero.
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_data   <= '0;
            r_out_cnt    <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_load) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_in_beat) begin
                r_acc <= w_acc_merge;
                r_cnt <= w_cnt_merge;
            end

            r_flush_pend <= w_flush_want && !w_slot_free;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_merge;
                r_out_cnt   <= w_cnt_merge;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= ^w_acc_merge;
        end
    end

    assign out_par = r_out_par;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream consumer of the 4-bit `b` stream produced by the `dut` stage. It accepts nibbles over a valid/ready handshake and packs them LSB-first into wide words. It presents each completed word, or a partial word on flush, through a single registered output slot with its own valid/ready handshake. It sits between the `intf` `b` channel and the word-oriented logic downstream.

## Interface
Parameters:
- `NIB_W`, 4, width of one input nibble (matches `intf` `b` width)
- `NIBS`, 4, nibbles per output word; must be ≥2
- Derived: `WORD_W = NIB_W*NIBS`; `CNT_W = $clog2(NIBS+1)`

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream nibble valid
- `in_ready`  out  1  packer can accept a nibble this cycle
- `in_data`  in  `NIB_W`  nibble (driven from `intf.b`)
- `flush`  in  1  single-cycle request to emit the partial word
- `out_valid`  out  1  output slot holds a word
- `out_ready`  in  1  downstream accepts the word this cycle
- `out_data`  out  `WORD_W`  packed word; nibble k is in bits [k*NIB_W +: NIB_W]
- `out_cnt`  out  `CNT_W`  number of valid nibbles in `out_data` (1..NIBS)

## Operation
- Accumulator holds 0..NIBS-1 nibbles, plus counter `cnt`. Output slot is one register set: `out_data`, `out_cnt`, `out_valid`.
- Input beat: `in_valid && in_ready`. The nibble is written at position `cnt`.
- Output beat: `out_valid && out_ready`. The slot frees in the same cycle.
- `slot_free = !out_valid || out_ready`.
- Word completion: an input beat with `cnt==NIBS-1` writes the full word into the slot, sets `out_cnt=NIBS`, and resets `cnt` to 0.
- `in_ready = rst_n && !flush_pend && (cnt < NIBS-1 || slot_free)`. The path from `out_ready` to `in_ready` is combinational.
- Flush is captured into `flush_pend` when `flush=1` and (`cnt>0` or an input beat occurs that cycle).
  - Emission happens when `slot_free`. The slot receives the accumulator zero-padded above `out_cnt` nibbles, `out_cnt=cnt`, and `cnt` clears to 0.
  - `flush` is ignored when `cnt==0` and there is no input beat.
  - `flush` is ignored while `flush_pend=1`.
- Input beat in the same cycle as `flush`: the nibble is included in the flushed word. If that beat completes the word, normal completion applies with `out_cnt=NIBS` and no separate flush.
- While `flush_pend=1`, `in_ready=0`.
- Unused upper nibbles of `out_data` are always 0.
- `out_data` and `out_cnt` hold stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync-safe deassert): `out_valid=0`, `out_data=0`, `out_cnt=0`, `cnt=0`, `flush_pend=0`, accumulator=0. `in_ready=0` while `rst_n=0`, and 1 on the first cycle after release.
- Latency: `out_valid` rises the cycle after the completing input beat.
- With `flush=1` and slot free, `out_valid` rises the cycle after the `flush` cycle.
- Throughput: 1 nibble/cycle sustained with `out_ready=1`; one word every NIBS cycles, with no bubbles at word boundaries.
- Back-pressure: with the slot full and `out_ready=0`, the packer accepts up to NIBS-1 further nibbles, then `in_ready` drops. The beat that fills the word is accepted in the same cycle `out_ready` returns.
- Reset mid-word or mid-flush discards the accumulator, pending flush and output slot immediately.
- `out_valid`, once high, stays high until an output beat occurs.

## Configuration
- `NIBBLE_PACKER_PARITY_EN`
  - Defined: adds output port `out_par` (1 bit, registered with the slot) = even parity (XOR-reduce) of the full `out_data`, padding included. Reset value 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then in_data 1,2,3,4 on consecutive cycles with `out_ready=1` -> next cycle `out_valid=1`, `out_data=16'h4321`, `out_cnt=4`; `in_ready` stays 1 throughout.
- Continuous stream 0..7 with `out_ready=1` -> two words `16'h3210`, `16'h7654`, `out_valid` high one cycle each, four cycles apart.
- `out_ready=0`, send 8 nibbles A..F,0,1 -> first word held as `16'hDCBA`; `in_ready` drops after 3 more accepted; raise `out_ready` -> 4th nibble accepted that cycle, next word `16'h10FE`.
- Send 5,6 then `flush` -> `out_data=16'h0065`, `out_cnt=2`; flush with `cnt==0` and no beat -> no output.
- Flush with the slot full, plus `in_valid` asserted -> `in_ready=0` until slot drains, then partial word emitted; mid-stream `rst_n=0` -> `out_valid=0`, `out_data=0` immediately; with `NIBBLE_PACKER_PARITY_EN`, word `16'h0007` -> `out_par=1`.
